is_line_loader: RTL and testbench
=================================

Name: is_line_loader

Overview:
- Upstream feeder for the 16-lane input-stationary MAC column datapath.
- Accepts a 32-bit word stream over a valid/ready handshake and packs 16 words into a 512-bit line.
- Issues one weight line with a single-cycle weight-enable pulse, then a programmable number of input lines, each with a single-cycle input-enable pulse.
- Issue pulses are gated by the IS clock-enable, so the downstream column never sees a pulse it would drop.

Parameters:
- LANES, 16, words per line; output bus width is LANES*WORD_W.
- WORD_W, 32, width of each stream word and each lane.
- CNT_W, 8, width of the input-line count port and its internal counter.

Ports:
- IS_CLK  in  1  clock; all logic on rising edge.
- IS_RST  in  1  reset, synchronous, active-high.
- IS_clk_is_enable  in  1  downstream enable; issue pulses only in cycles where it is high.
- IS_start  in  1  one-cycle job start; ignored unless in IDLE.
- IS_num_lines  in  CNT_W  input lines per job; sampled on accepted IS_start; 0 treated as 1.
- s_valid  in  1  stream word valid.
- s_data  in  WORD_W  stream word.
- s_ready  out  1  loader can accept a word this cycle.
- IS_In_o  out  LANES*WORD_W  issued line, to the datapath line input.
- IS_enW_o  out  1  weight-line pulse.
- IS_enI_o  out  1  input-line pulse.
- IS_busy  out  1  high in every state except IDLE.
- IS_done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset values: IS_In_o=0, IS_enW_o=0, IS_enI_o=0, s_ready=0, IS_busy=0, IS_done=0, FSM=IDLE, word counter=0, line counter=0, assembly register=0.
- Reset asserted mid-job aborts immediately. No pulse is emitted on the reset edge or afterwards until a new IS_start.
- Registers: a separate assembly register and output register. IS_In_o changes only on issue edges and holds its value between pulses and after DONE.
- Packing: word k of a line (k=0 first accepted) lands in IS_In_o[(LANES-k)*WORD_W-1 -: WORD_W]. Word 0 goes to [511:480]; word 15 goes to [31:0].
- Handshake: a word is transferred when s_valid && s_ready. s_ready is combinational from state: 1 in FILL_W and FILL_I, 0 elsewhere. s_data is ignored when not transferred.
- FSM states: IDLE, FILL_W, WAIT_W, FILL_I, WAIT_I, DONE.
- IDLE: on IS_start, latch lines_left = max(IS_num_lines,1), clear the word counter, go to FILL_W.
- FILL_W, on the edge accepting word LANES-1:
  - if IS_clk_is_enable=1 that cycle: load the output register with the completed line, set IS_enW_o=1 for the next cycle, go to FILL_I.
  - else go to WAIT_W.
- WAIT_W: on the first edge with IS_clk_is_enable=1, load the output register, pulse IS_enW_o, go to FILL_I.
- FILL_I / WAIT_I: identical timing, but pulse IS_enI_o and decrement lines_left on issue. If lines_left was 1, go to DONE; else go to FILL_I.
- DONE: IS_done=1 for exactly one cycle, then IDLE.
- Latency: one pulse appears in the cycle after the last word is accepted, if enable was high on that edge. Otherwise it appears in the cycle after the first enabled edge.
- IS_enW_o and IS_enI_o are never high together. Each pulse is exactly one cycle wide.
- Filling is independent of IS_clk_is_enable. Only issue waits on it.
- Gaps in s_valid stall the fill with no loss or reordering.
- IS_start while busy is ignored, with no effect on state or counters.
- Lines per job: exactly 1 weight line plus lines_left input lines; the word counter wraps 15 to 0 at each line boundary.

Test Plan:
- Reset, then IS_start with IS_num_lines=2, enable held 1, stream words 0x00000001..0x00000030 back-to-back:
  - IS_enW_o pulses once with IS_In_o[511:480]=0x1 and [31:0]=0x10.
  - IS_enI_o pulses twice, with lines 0x11..0x20 and 0x21..0x30.
  - IS_done pulses 1 cycle after the second issue.
  - 48 words accepted in total.
- Same job with IS_clk_is_enable=0 for 5 cycles around the 16th word:
  - State holds in WAIT_W and s_ready=0.
  - IS_enW_o pulses in the cycle after enable returns; IS_In_o is unchanged before that.
- s_valid toggling 1/0 every cycle during the fill: line contents are identical to the back-to-back case and pulse count is unchanged.
- IS_num_lines=0: one weight line then exactly one input line, then IS_done.
- IS_start pulsed during FILL_I: no restart, and the remaining pulse count is unchanged.
- IS_RST asserted for 1 cycle after 7 words of an input line:
  - All outputs return to 0 and no pulse follows.
  - A new job then behaves as in the first scenario.

Source files
------------

// File: rtl/is_line_loader.sv
// -----------------------------------------------------------------------------
// is_line_loader
//   Upstream feeder for the 16-lane input-stationary MAC column. It packs a
//   32-bit valid/ready word stream into LANES-word lines. For each job it issues
//   one weight line (IS_enW_o pulse) and then lines_left input lines (IS_enI_o
//   pulses). An issue happens only on an edge where IS_clk_is_enable is high,
//   so the column never misses a pulse.
//
// Ports
//   IS_CLK            clock, all logic on the rising edge
//   IS_RST            synchronous active-high reset
//   IS_clk_is_enable  downstream enable, gates every issue
//   IS_start          one-cycle job start, honoured only in IDLE
//   IS_num_lines      input lines per job, 0 is treated as 1
//   s_valid/s_data    stream word in
//   s_ready           loader accepts a word this cycle
//   IS_In_o           issued line; word 0 sits in the most significant lane
//   IS_enW_o          one-cycle weight-line pulse
//   IS_enI_o          one-cycle input-line pulse
//   IS_busy           high outside IDLE
//   IS_done           one-cycle job-complete pulse
// -----------------------------------------------------------------------------
module is_line_loader #(
  parameter int LANES  = 16,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                    IS_CLK,
  input  logic                    IS_RST,
  input  logic                    IS_clk_is_enable,
  input  logic                    IS_start,
  input  logic [CNT_W-1:0]        IS_num_lines,
  input  logic                    s_valid,
  input  logic [WORD_W-1:0]       s_data,
  output logic                    s_ready,
  output logic [LANES*WORD_W-1:0] IS_In_o,
  output logic                    IS_enW_o,
  output logic                    IS_enI_o,
  output logic                    IS_busy,
  output logic                    IS_done
);

  localparam int LINE_W = LANES * WORD_W;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE, FILL_W, WAIT_W, FILL_I, WAIT_I, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  lines_left_q;
  logic [LINE_W-1:0] asm_q, asm_d;
  logic [LINE_W-1:0] out_q;
  logic              enw_q, eni_q;

  logic accept, last_word, start_job, issue_w, issue_i;

  assign s_ready   = (state_q == FILL_W) || (state_q == FILL_I);
  assign accept    = s_valid && s_ready;
  assign last_word = accept && (word_cnt_q == LAST_IDX);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    start_job = 1'b0;
    issue_w   = 1'b0;
    issue_i   = 1'b0;
    asm_d     = asm_q;

    // Drop the accepted word into its lane; the completed line (including the
    // word arriving this cycle) is then visible in asm_d for an immediate issue.
    for (int k = 0; k < LANES; k++) begin
      if (accept && (word_cnt_q == IDX_W'(k)))
        asm_d[(LANES-1-k)*WORD_W +: WORD_W] = s_data;
    end

    unique case (state_q)
      IDLE: begin
        if (IS_start) begin
          start_job = 1'b1;
          state_d   = FILL_W;
        end
      end
      FILL_W: begin
        if (last_word) begin
          if (IS_clk_is_enable) begin
            issue_w = 1'b1;
            state_d = FILL_I;
          end else begin
            state_d = WAIT_W;
          end
        end
      end
      WAIT_W: begin
        if (IS_clk_is_enable) begin
          issue_w = 1'b1;
          state_d = FILL_I;
        end
      end
      FILL_I: begin
        if (last_word) begin
          if (IS_clk_is_enable) begin
            issue_i = 1'b1;
            state_d = (lines_left_q == CNT_W'(1)) ? DONE : FILL_I;
          end else begin
            state_d = WAIT_I;
          end
        end
      end
      WAIT_I: begin
        if (IS_clk_is_enable) begin
          issue_i = 1'b1;
          state_d = (lines_left_q == CNT_W'(1)) ? DONE : FILL_I;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge IS_CLK) begin
    if (IS_RST) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      lines_left_q <= '0;
      // NOTE: the line-wide assembly and output registers are reset too, so a
      // line is never issued with stale lanes after an aborted job.
      asm_q        <= '0;
      out_q        <= '0;
      enw_q        <= 1'b0;
      eni_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      enw_q   <= issue_w;
      eni_q   <= issue_i;

      if (start_job) begin
        word_cnt_q   <= '0;
        lines_left_q <= (IS_num_lines == '0) ? CNT_W'(1) : IS_num_lines;
      end else if (accept) begin
        word_cnt_q <= last_word ? '0 : word_cnt_q + IDX_W'(1);
      end

      if (issue_i)
        lines_left_q <= lines_left_q - CNT_W'(1);

      // The output only moves on an issue edge and holds otherwise.
      if (issue_w || issue_i)
        out_q <= asm_d;
    end
  end

  assign IS_In_o  = out_q;
  assign IS_enW_o = enw_q;
  assign IS_enI_o = eni_q;
  assign IS_busy  = (state_q != IDLE);
  assign IS_done  = (state_q == DONE);

endmodule

// File: tb/tb_is_line_loader.sv
// -----------------------------------------------------------------------------
// tb_is_line_loader
//   Scoreboarded bench for is_line_loader. Job tasks push the expected issue
//   sequence (weight line, input lines, done) into a queue; a monitor on the
//   falling edge pops and compares whenever the DUT pulses.
// -----------------------------------------------------------------------------
module tb_is_line_loader;

  localparam int LANES  = 16;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 8;
  localparam int LINE_W = LANES * WORD_W;

  localparam logic [1:0] K_W = 2'd0;
  localparam logic [1:0] K_I = 2'd1;
  localparam logic [1:0] K_D = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic [LINE_W-1:0] line;
  } exp_t;

  logic              IS_CLK = 1'b0;
  logic              IS_RST;
  logic              IS_clk_is_enable;
  logic              IS_start;
  logic [CNT_W-1:0]  IS_num_lines;
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;
  logic [LINE_W-1:0] IS_In_o;
  logic              IS_enW_o, IS_enI_o, IS_busy, IS_done;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc_cnt = 0;

  is_line_loader #(.LANES(LANES), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .IS_CLK(IS_CLK), .IS_RST(IS_RST), .IS_clk_is_enable(IS_clk_is_enable),
    .IS_start(IS_start), .IS_num_lines(IS_num_lines),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .IS_In_o(IS_In_o), .IS_enW_o(IS_enW_o), .IS_enI_o(IS_enI_o),
    .IS_busy(IS_busy), .IS_done(IS_done)
  );

  always #5 IS_CLK = ~IS_CLK;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Line of 16 consecutive words starting at 'first'; word 0 in the top lane.
  function automatic logic [LINE_W-1:0] mk_line(input int first);
    logic [LINE_W-1:0] l = '0;
    for (int k = 0; k < LANES; k++)
      l[(LANES-k)*WORD_W-1 -: WORD_W] = WORD_W'(first + k);
    return l;
  endfunction

  // Monitor: decoupled from stimulus, pops on every pulse.
  always @(negedge IS_CLK) begin
    if (!IS_RST) begin
      exp_t e;
      if (s_valid && s_ready) acc_cnt++;
      if (IS_enW_o && IS_enI_o) check("pulses_exclusive", 1, 0);
      if (IS_enW_o || IS_enI_o) begin
        check("sb_empty_on_pulse", LINE_W'(sb.size() == 0), 0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("pulse_kind", LINE_W'(IS_enW_o ? K_W : K_I), LINE_W'(e.kind));
          check("line_data", IS_In_o, e.line);
        end
      end
      if (IS_done) begin
        check("sb_empty_on_done", LINE_W'(sb.size() == 0), 0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("done_kind", LINE_W'(K_D), LINE_W'(e.kind));
        end
      end
    end
  end

  task automatic tick();
    @(posedge IS_CLK); #1;
  endtask

  // Offers one word; returns #1 after the edge on which it was accepted.
  task automatic push_word(input int w);
    int t = 0;
    s_valid = 1'b1;
    s_data  = WORD_W'(w);
    forever begin
      @(negedge IS_CLK);
      if (s_ready) begin
        tick();
        break;
      end
      @(posedge IS_CLK); #1;
      t++;
      if (t > 200) begin
        check("word_accept_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic idle_stream();
    s_valid = 1'b0;
    s_data  = 32'hDEAD_BEEF;
  endtask

  task automatic send_words(input int first, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      push_word(first + i);
      if (gap) begin
        idle_stream();
        tick();
      end
    end
    idle_stream();
  endtask

  // Pulses IS_start and pushes the expected issue sequence.
  task automatic start_job(input int n, input int first);
    int   nl;
    exp_t e;
    nl = (n == 0) ? 1 : n;
    e.kind = K_W; e.line = mk_line(first); sb.push_back(e);
    for (int i = 0; i < nl; i++) begin
      e.kind = K_I; e.line = mk_line(first + LANES * (i + 1)); sb.push_back(e);
    end
    e.kind = K_D; e.line = '0; sb.push_back(e);
    acc_cnt      = 0;
    IS_start     = 1'b1;
    IS_num_lines = CNT_W'(n);
    tick();
    IS_start     = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    forever begin
      @(negedge IS_CLK);
      if (!IS_busy) break;
      t++;
      if (t > 200) begin
        check("idle_timeout", 1, 0);
        break;
      end
    end
    check("sb_drained", LINE_W'(sb.size()), 0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge IS_CLK);
    check({tag, "_In"},    IS_In_o, 0);
    check({tag, "_enW"},   LINE_W'(IS_enW_o), 0);
    check({tag, "_enI"},   LINE_W'(IS_enI_o), 0);
    check({tag, "_ready"}, LINE_W'(s_ready), 0);
    check({tag, "_busy"},  LINE_W'(IS_busy), 0);
    check({tag, "_done"},  LINE_W'(IS_done), 0);
    tick();
  endtask

  initial begin
    logic [LINE_W-1:0] held;
    IS_RST = 1'b1; IS_clk_is_enable = 1'b1; IS_start = 1'b0;
    IS_num_lines = '0;
    idle_stream();
    repeat (3) tick();
    IS_RST = 1'b0;
    check_all_zero("reset");

    // 1: baseline job, two input lines, words 0x01..0x30 back-to-back.
    start_job(2, 1);
    send_words(1, 48, 1'b0);
    wait_idle();
    check("s1_words", LINE_W'(acc_cnt), 48);
    check("s1_hold_top", LINE_W'(IS_In_o[511:480]), 32'h21);
    check("s1_hold_bot", LINE_W'(IS_In_o[31:0]), 32'h30);

    // 2: enable low for 5 edges around the 16th word.
    held = IS_In_o;
    start_job(2, 1);
    send_words(1, 15, 1'b0);
    IS_clk_is_enable = 1'b0;
    push_word(16);
    idle_stream();
    for (int i = 0; i < 4; i++) begin
      @(negedge IS_CLK);
      check("s2_wait_ready", LINE_W'(s_ready), 0);
      check("s2_wait_busy",  LINE_W'(IS_busy), 1);
      check("s2_wait_enW",   LINE_W'(IS_enW_o), 0);
      check("s2_wait_hold",  IS_In_o, held);
      tick();
    end
    IS_clk_is_enable = 1'b1;
    @(negedge IS_CLK);
    check("s2_pre_enW", LINE_W'(IS_enW_o), 0);
    tick();
    @(negedge IS_CLK);
    check("s2_post_enW", LINE_W'(IS_enW_o), 1);
    tick();
    send_words(17, 32, 1'b0);
    wait_idle();
    check("s2_words", LINE_W'(acc_cnt), 48);

    // 3: s_valid toggling every cycle.
    start_job(2, 1);
    send_words(1, 48, 1'b1);
    wait_idle();
    check("s3_words", LINE_W'(acc_cnt), 48);

    // 4: IS_num_lines = 0 behaves as one input line.
    start_job(0, 32'h100);
    send_words(32'h100, 32, 1'b0);
    wait_idle();
    check("s4_words", LINE_W'(acc_cnt), 32);

    // 5: IS_start during FILL_I is ignored.
    start_job(2, 1);
    send_words(1, 20, 1'b0);
    IS_start = 1'b1; IS_num_lines = 8'd5;
    push_word(21);
    IS_start = 1'b0;
    send_words(22, 27, 1'b0);
    wait_idle();
    check("s5_words", LINE_W'(acc_cnt), 48);

    // 6: reset after 7 words of the first input line aborts the job.
    start_job(2, 1);
    send_words(1, 23, 1'b0);
    IS_RST = 1'b1;
    tick();
    IS_RST = 1'b0;
    sb.delete();
    check_all_zero("s6_rst");
    repeat (20) tick();
    check("s6_quiet_busy", LINE_W'(IS_busy), 0);
    start_job(2, 1);
    send_words(1, 48, 1'b0);
    wait_idle();
    check("s6_words", LINE_W'(acc_cnt), 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
